// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker that stalls issue on unforwardable RAW/WAW hazards
module reg_scoreboard #(
   parameter int NREG  = 16,
   parameter int AW    = 4,
   parameter int LAT_W = 3,
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_issue_valid,
   input  logic             i_issue_wen,
   input  logic [AW-1:0]    i_issue_dst,
   input  logic [LAT_W-1:0] i_issue_lat,
   input  logic             i_use_src1,
   input  logic [AW-1:0]    i_src1,
   input  logic             i_use_src2,
   input  logic [AW-1:0]    i_src2,
   input  logic             i_flush,
   output logic             o_stall,
   output logic [NREG-1:0]  o_busy_vec,
   output logic [CNT_W-1:0] o_stall_cycles
);
   logic [LAT_W-1:0] r_pend [NREG];
   logic [CNT_W-1:0] r_cnt;
   logic             w_raw1, w_raw2, w_waw, w_live, w_rec;
   assign w_live  = i_issue_valid && !i_flush;
   assign w_raw1  = i_use_src1 && i_src1 != '0 && r_pend[i_src1] != '0;
   assign w_raw2  = i_use_src2 && i_src2 != '0 && r_pend[i_src2] != '0;
   assign w_waw   = i_issue_wen && i_issue_dst != '0 && r_pend[i_issue_dst] > i_issue_lat;
   assign o_stall = w_live && (w_raw1 || w_raw2 || w_waw);
   // a write is tracked only when accepted with a real destination and nonzero latency
   assign w_rec   = w_live && !o_stall && i_issue_wen && i_issue_dst != '0 && i_issue_lat != '0;
   assign o_stall_cycles = r_cnt;
   // pending counters: flush clears, an accepted write loads, otherwise count down to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (i_flush) r_pend[i] <= '0;
            else if (w_rec && i_issue_dst == AW'(i)) r_pend[i] <= i_issue_lat;
            else if (r_pend[i] != '0) r_pend[i] <= r_pend[i] - LAT_W'(1);
         end
      end
   end
   // busy flags straight from the counters; register 0 is never busy
   always_comb begin
      o_busy_vec = '0;
      for (int i = 1; i < NREG; i++) o_busy_vec[i] = r_pend[i] != '0;
   end
   // saturating count of stalled cycles, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (o_stall && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
   end
endmodule
